mmio_regfile: RTL

- Parametrised successor to the single-word MMIO block: a bank of NUM_REGS memory-mapped registers behind the same addr/data/wr/rd bus.
- Adds:
  - byte-enable writes;
  - a configurable, pipelined read latency;
  - a read-only hardware status word;
  - a write-1-to-clear interrupt-pending register with enable mask and level IRQ;
  - address-error reporting.
- Sits between the testbench/CPU bus model and block-level control/status signals.

---
 rtl/mmio_regfile.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mmio_regfile.sv
// Memory-mapped register bank: CTRL registers, a live STATUS word, W1C interrupt
// pending/enable pair with level IRQ, and a pipelined read path with error reporting.
module mmio_regfile #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              addr_in,
    input  logic [DATA_W-1:0]              data_in,
    input  logic [DATA_W/8-1:0]            be_in,
    input  logic                           wr_in,
    input  logic                           rd_in,
    output logic                           rd_valid_out,
    output logic [DATA_W-1:0]              data_out,
    output logic                           err_out,
    input  logic [DATA_W-1:0]              hw_status_in,
    input  logic [DATA_W-1:0]              irq_set_in,
    output logic [(NUM_REGS-3)*DATA_W-1:0] ctrl_out,
    output logic                           irq_out
);

    localparam int unsigned BW         = DATA_W / 8;
    localparam int unsigned OFF_W      = $clog2(BW);
    localparam int unsigned IDX_W      = $clog2(NUM_REGS);
    localparam int unsigned NUM_CTRL   = NUM_REGS - 3;
    localparam int unsigned STATUS_IDX = NUM_REGS - 3;
    localparam int unsigned PEND_IDX   = NUM_REGS - 2;
    localparam int unsigned EN_IDX     = NUM_REGS - 1;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] wordIdx;
    logic [IDX_W-1:0]  regIdx;
    logic              addrOk;
    logic              wrHit;
    logic [DATA_W-1:0] wrMask;
    logic [DATA_W-1:0] w1cMask;
    logic [DATA_W-1:0] rdData;

    logic [DATA_W-1:0] ctrl_q [NUM_CTRL];
    logic [DATA_W-1:0] ctrl_d [NUM_CTRL];
    logic [DATA_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] en_q, en_d;
    logic              irq_q;
    logic              wrErr_q;

    logic [RD_LATENCY-1:0] pipeValid_q;
    logic [RD_LATENCY-1:0] pipeErr_q;
    logic [DATA_W-1:0]     pipeData_q [RD_LATENCY];

    // Subtraction is only meaningful once addr_in >= BASE_ADDR, which addrOk also requires.
    always_comb begin
        offset  = addr_in - ADDR_W'(BASE_ADDR);
        wordIdx = offset >> OFF_W;
        regIdx  = wordIdx[IDX_W-1:0];
        addrOk  = (addr_in >= ADDR_W'(BASE_ADDR)) &&
                  (addr_in[OFF_W-1:0] == '0) &&
                  (wordIdx < ADDR_W'(NUM_REGS));
        wrHit   = wr_in && addrOk;
    end

    always_comb begin
        wrMask = '0;
        for (int b = 0; b < BW; b++) begin
            wrMask[b*8 +: 8] = {8{be_in[b]}};
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        en_d    = en_q;
        w1cMask = '0;
        if (wrHit) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (regIdx == IDX_W'(i)) begin
                    ctrl_d[i] = (ctrl_q[i] & ~wrMask) | (data_in & wrMask);
                end
            end
            if (regIdx == IDX_W'(EN_IDX)) begin
                en_d = (en_q & ~wrMask) | (data_in & wrMask);
            end
            if (regIdx == IDX_W'(PEND_IDX)) begin
                w1cMask = data_in & wrMask;
            end
        end
        // A set pulse on the same bit as a clear wins.
        pend_d = (pend_q & ~w1cMask) | irq_set_in;
    end

    always_comb begin
        rdData = '0;
        if (addrOk) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (regIdx == IDX_W'(i)) begin
                    rdData = ctrl_q[i];
                end
            end
            if (regIdx == IDX_W'(STATUS_IDX)) rdData = hw_status_in;
            if (regIdx == IDX_W'(PEND_IDX))   rdData = pend_q;
            if (regIdx == IDX_W'(EN_IDX))     rdData = en_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_q[i] <= '0;
            end
            pend_q  <= '0;
            en_q    <= '0;
            irq_q   <= 1'b0;
            wrErr_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            irq_q   <= |(pend_d & en_d);
            wrErr_q <= wr_in && !addrOk;
        end
    end

    // Data stages only load behind a valid read, so the last stage holds the previous result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipeValid_q <= '0;
            pipeErr_q   <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipeData_q[s] <= '0;
            end
        end else begin
            pipeValid_q[0] <= rd_in;
            pipeErr_q[0]   <= rd_in && !addrOk;
            if (rd_in) begin
                pipeData_q[0] <= rdData;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipeValid_q[s] <= pipeValid_q[s-1];
                pipeErr_q[s]   <= pipeErr_q[s-1];
                if (pipeValid_q[s-1]) begin
                    pipeData_q[s] <= pipeData_q[s-1];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : gCtrlOut
        assign ctrl_out[g*DATA_W +: DATA_W] = ctrl_q[g];
    end

    assign rd_valid_out = pipeValid_q[RD_LATENCY-1];
    assign data_out     = pipeData_q[RD_LATENCY-1];
    assign err_out      = wrErr_q | pipeErr_q[RD_LATENCY-1];
    assign irq_out      = irq_q;

endmodule
